// File: rtl/cook_timer.sv
// Countdown cook timer: BCD MM:SS keypad entry while the magnetron is off,
// one-second countdown while mag_on is high, done level and done pulse outputs.
module cook_timer #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clearn,
  input  logic       mag_on,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       timer_done,
  output logic       done_pulse
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICKS_PER_SEC - 1);

  logic [3:0]    sec_ones_q, sec_ones_d;
  logic [3:0]    sec_tens_q, sec_tens_d;
  logic [3:0]    min_ones_q, min_ones_d;
  logic [3:0]    min_tens_q, min_tens_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          done_q, done_d;
  logic          pulse_q, pulse_d;
  logic          time_nz;
  logic          key_ok;

  assign time_nz = |{sec_ones_q, sec_tens_q, min_ones_q, min_tens_q};
  assign key_ok  = key_valid && !mag_on && (key_digit <= 4'd9);

  always_comb begin
    sec_ones_d = sec_ones_q;
    sec_tens_d = sec_tens_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    presc_d    = presc_q;
    pulse_d    = 1'b0;

    if (!clearn) begin
      sec_ones_d = 4'd0;
      sec_tens_d = 4'd0;
      min_ones_d = 4'd0;
      min_tens_d = 4'd0;
      presc_d    = '0;
    end else if (key_ok) begin
      min_tens_d = min_ones_q;
      min_ones_d = sec_tens_q;
      sec_tens_d = sec_ones_q;
      sec_ones_d = key_digit;
    end else if (mag_on && time_nz) begin
      if (presc_q == TICK_LAST) begin
        presc_d = '0;
        // BCD borrow chain; sec_tens borrows to 5 so entered 6-9 values drain as raw seconds
        if (sec_ones_q != 4'd0) begin
          sec_ones_d = sec_ones_q - 4'd1;
        end else begin
          sec_ones_d = 4'd9;
          if (sec_tens_q != 4'd0) begin
            sec_tens_d = sec_tens_q - 4'd1;
          end else begin
            sec_tens_d = 4'd5;
            if (min_ones_q != 4'd0) begin
              min_ones_d = min_ones_q - 4'd1;
            end else begin
              min_ones_d = 4'd9;
              min_tens_d = min_tens_q - 4'd1;
            end
          end
        end
        pulse_d = ~|{sec_ones_d, sec_tens_d, min_ones_d, min_tens_d};
      end else begin
        presc_d = presc_q + PW'(1);
      end
    end

    // Computed from the next digits so the done level moves on the same edge
    done_d = ~|{sec_ones_d, sec_tens_d, min_ones_d, min_tens_d};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sec_ones_q <= 4'd0;
      sec_tens_q <= 4'd0;
      min_ones_q <= 4'd0;
      min_tens_q <= 4'd0;
      presc_q    <= '0;
      done_q     <= 1'b1;
      pulse_q    <= 1'b0;
    end else begin
      sec_ones_q <= sec_ones_d;
      sec_tens_q <= sec_tens_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      presc_q    <= presc_d;
      done_q     <= done_d;
      pulse_q    <= pulse_d;
    end
  end

  assign sec_ones   = sec_ones_q;
  assign sec_tens   = sec_tens_q;
  assign min_ones   = min_ones_q;
  assign min_tens   = min_tens_q;
  assign timer_done = done_q;
  assign done_pulse = pulse_q;

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with a 4-cycle second: vector table plus
// hand-written pause, borrow, clear and async-reset sequences.
module tb_cook_timer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       clearn = 1'b1;
  logic       mag_on = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
  logic       timer_done, done_pulse;

  int checks = 0;
  int errors = 0;

  cook_timer #(.TICKS_PER_SEC(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clearn     (clearn),
    .mag_on     (mag_on),
    .key_valid  (key_valid),
    .key_digit  (key_digit),
    .sec_ones   (sec_ones),
    .sec_tens   (sec_tens),
    .min_ones   (min_ones),
    .min_tens   (min_tens),
    .timer_done (timer_done),
    .done_pulse (done_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clearn;
    logic        mag_on;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic [15:0] exp_t;
    logic        exp_done;
    logic        exp_pulse;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string nm, input logic [15:0] exp_t,
                     input logic exp_done, input logic exp_pulse);
    logic [15:0] got_t;
    got_t = {min_tens, min_ones, sec_tens, sec_ones};
    checks++;
    if (got_t !== exp_t || timer_done !== exp_done || done_pulse !== exp_pulse) begin
      errors++;
      $display("FAIL %s: got time=%h done=%b pulse=%b, expected time=%h done=%b pulse=%b",
               nm, got_t, timer_done, done_pulse, exp_t, exp_done, exp_pulse);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // Clears, then keys four digits MSB first with the magnetron off
  task automatic load(input logic [15:0] t);
    logic [15:0] tv;
    tv = t;
    mag_on = 1'b0; key_valid = 1'b0; clearn = 1'b0;
    cyc();
    clearn = 1'b1;
    for (int i = 3; i >= 0; i--) begin
      key_valid = 1'b1;
      key_digit = tv[i*4 +: 4];
      cyc();
    end
    key_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 4'h1, 16'h0001, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 4'h2, 16'h0012, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'h3, 16'h0123, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'h0, 16'h1230, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'hA, 16'h1230, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 4'h7, 16'h1230, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'h5, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 4'h0, 16'h0000, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'h0, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 4'h2, 16'h0002, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 4'h0, 16'h0002, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 4'h0, 16'h0002, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 4'h0, 16'h0002, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 4'h0, 16'h0001, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 4'h0, 16'h0001, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b1, 1'b0, 4'h0, 16'h0001, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 4'h0, 16'h0001, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b1};
    vecs[19] = '{1'b1, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b1, 1'b0};

    #12;
    chk("reset_state", 16'h0000, 1'b1, 1'b0);
    resetn = 1'b1;
    run(2);
    chk("idle_after_reset", 16'h0000, 1'b1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      clearn    = vecs[i].clearn;
      mag_on    = vecs[i].mag_on;
      key_valid = vecs[i].key_valid;
      key_digit = vecs[i].key_digit;
      cyc();
      chk($sformatf("vec_%0d", i), vecs[i].exp_t, vecs[i].exp_done, vecs[i].exp_pulse);
    end
    key_valid = 1'b0;

    for (int i = 0; i < 20; i++) begin
      cyc();
      chk($sformatf("no_rollover_%0d", i), 16'h0000, 1'b1, 1'b0);
    end

    load(16'h1000);
    chk("load_10_00", 16'h1000, 1'b0, 1'b0);
    mag_on = 1'b1;
    run(4);
    chk("borrow_10_00", 16'h0959, 1'b0, 1'b0);

    load(16'h0099);
    chk("load_00_99", 16'h0099, 1'b0, 1'b0);
    mag_on = 1'b1;
    run(4);
    chk("raw_99_98", 16'h0098, 1'b0, 1'b0);
    run(32);
    chk("raw_to_90", 16'h0090, 1'b0, 1'b0);
    run(4);
    chk("borrow_90_89", 16'h0089, 1'b0, 1'b0);

    load(16'h0005);
    mag_on = 1'b1;
    run(2);
    chk("pause_before", 16'h0005, 1'b0, 1'b0);
    mag_on = 1'b0;
    run(10);
    chk("pause_hold", 16'h0005, 1'b0, 1'b0);
    mag_on = 1'b1;
    cyc();
    chk("resume_1", 16'h0005, 1'b0, 1'b0);
    cyc();
    chk("resume_2", 16'h0004, 1'b0, 1'b0);

    load(16'h0317);
    mag_on = 1'b1;
    run(2);
    clearn = 1'b0;
    cyc();
    chk("clear_mid_count", 16'h0000, 1'b1, 1'b0);
    clearn = 1'b1;
    cyc();
    chk("after_clear", 16'h0000, 1'b1, 1'b0);

    load(16'h0317);
    mag_on = 1'b1;
    run(3);
    #1;
    resetn = 1'b0;
    #1;
    chk("async_reset", 16'h0000, 1'b1, 1'b0);
    @(negedge clk);
    resetn = 1'b1;
    mag_on = 1'b0;
    cyc();
    chk("after_reset", 16'h0000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
